// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared definitions for the debug hex monitor: the monitor state encoding and
// the width of one hex digit.
// -----------------------------------------------------------------------------
package debug_pkg;

    // Width of one hex digit nibble on the display bus.
    localparam int DIGIT_W = 4;

    // Monitor operating states.
    //   ST_RUN    : display follows ch_sel on every refresh, step advances ch_sel
    //   ST_FROZEN : display and ch_sel held while the freeze level is high
    //   ST_HOLD   : display captured by a breakpoint hit, waits for a step press
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FROZEN = 2'd1,
        ST_HOLD   = 2'd2
    } mon_state_e;

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Brings a raw, asynchronous push-button into the clock domain through a
// two-flop synchroniser, filters contact bounce, and emits a one-cycle pulse
// on each rising edge of the filtered level.
//
// Ports
//   clk        : clock, all state updates on its rising edge
//   rst_n      : asynchronous active-low reset
//   btn_raw    : raw active-high button, asynchronous to clk
//   step_pulse : registered one-cycle pulse per accepted press
// -----------------------------------------------------------------------------
module btn_debounce
    import debug_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic step_pulse
);

    // Counter must be able to reach DEBOUNCE_CYC-1.
    localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;

    logic            sync_p0;
    logic            sync_p1;
    logic            btn_level;
    logic [DB_W-1:0] stable_cnt;

    // ---- stage p0/p1: metastability synchroniser ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // ---- stage p2: debounce filter and edge pulse ----
    // stable_cnt counts consecutive samples that disagree with the accepted
    // level; any agreeing sample restarts the count, so a bounce shorter than
    // DEBOUNCE_CYC samples never reaches the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_level  <= 1'b0;
            stable_cnt <= '0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            if (sync_p1 == btn_level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
                btn_level  <= sync_p1;
                stable_cnt <= '0;
                step_pulse <= sync_p1;
            end else begin
                stable_cnt <= stable_cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/debug_hex_monitor.sv
// -----------------------------------------------------------------------------
// debug_hex_monitor
// Shows one of NUM_CH debug channels on a row of hex digits. A debounced step
// button walks through the channels, a freeze level holds the display, and a
// bus-address breakpoint captures the selected channel and holds it until the
// next step press.
//
// Ports
//   MCLK       : clock, all state updates on its rising edge
//   reset_n    : asynchronous active-low reset
//   ch_data    : packed channels, channel k at [k*CH_W +: CH_W]
//   step_btn   : raw active-high step button, asynchronous to MCLK
//   freeze     : level, holds the current display while high
//   bp_en      : breakpoint enable
//   bp_addr    : breakpoint address
//   bus_addr   : CPU bus address
//   bus_valid  : bus_addr valid this cycle
//   hex_digits : nibble i drives hex digit i (registered)
//   ch_sel     : selected channel (registered)
//   bp_hit     : sticky breakpoint flag (registered)
//   hit_count  : saturating breakpoint hit counter (registered)
// -----------------------------------------------------------------------------
module debug_hex_monitor
    import debug_pkg::*;
#(
    parameter int NUM_CH       = 8,
    parameter int CH_W         = 16,
    parameter int NUM_DIGITS   = 6,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int REFRESH_DIV  = 2500000
) (
    input  logic                          MCLK,
    input  logic                          reset_n,
    input  logic [NUM_CH*CH_W-1:0]        ch_data,
    input  logic                          step_btn,
    input  logic                          freeze,
    input  logic                          bp_en,
    input  logic [15:0]                   bp_addr,
    input  logic [15:0]                   bus_addr,
    input  logic                          bus_valid,
    output logic [DIGIT_W*NUM_DIGITS-1:0] hex_digits,
    output logic [$clog2(NUM_CH)-1:0]     ch_sel,
    output logic                          bp_hit,
    output logic [7:0]                    hit_count
);

    localparam int SEL_W = $clog2(NUM_CH);
    localparam int RC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HEX_W = DIGIT_W * NUM_DIGITS;

    // Hit counter holds at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Display layout: channel value in the low digits, channel number in the
    // top digit (size cast zero-extends or truncates to one nibble), zeros
    // in between.
    function automatic logic [HEX_W-1:0] pack_digits(input logic [CH_W-1:0]  d,
                                                     input logic [SEL_W-1:0] s);
        logic [HEX_W-1:0] r;
        r                            = '0;
        r[CH_W-1:0]                  = d;
        r[HEX_W-1 -: DIGIT_W]        = DIGIT_W'(s);
        return r;
    endfunction

    logic                  step_pulse;
    logic [RC_W-1:0]       refresh_cnt;
    logic                  refresh_tick;
    logic                  hit;
    mon_state_e            state;
    logic [CH_W-1:0]       disp_p0;
    logic [CH_W-1:0]       ch_arr [NUM_CH];
    logic [CH_W-1:0]       sel_data;
    logic [SEL_W-1:0]      next_sel;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn_debounce (
        .clk        (MCLK),
        .rst_n      (reset_n),
        .btn_raw    (step_btn),
        .step_pulse (step_pulse)
    );

    // Refresh timebase: tick is high during the last count, so the consuming
    // edge is the one where the counter wraps.
    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            refresh_cnt <= '0;
        end else if (refresh_tick) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + RC_W'(1);
        end
    end

    assign refresh_tick = (refresh_cnt == RC_W'(REFRESH_DIV - 1));

    assign hit = bp_en & bus_valid & (bus_addr == bp_addr);

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            ch_arr[k] = ch_data[k*CH_W +: CH_W];
        end
    end

    assign sel_data = ch_arr[ch_sel];
    assign next_sel = (ch_sel == SEL_W'(NUM_CH - 1)) ? '0 : ch_sel + SEL_W'(1);

    // ---- stage p0: control state, channel select, display register ----
    // A hit in RUN wins over both a refresh and a step in the same cycle, and
    // freeze wins over refresh/step, so the captured or frozen value is never
    // overwritten on the edge that enters the holding state.
    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            ch_sel    <= '0;
            disp_p0   <= '0;
            bp_hit    <= 1'b0;
            hit_count <= '0;
        end else begin
            if (hit) begin
                bp_hit    <= 1'b1;
                hit_count <= sat_inc8(hit_count);
            end

            unique case (state)
                ST_RUN: begin
                    if (hit) begin
                        disp_p0 <= sel_data;
                        state   <= ST_HOLD;
                    end else if (freeze) begin
                        state <= ST_FROZEN;
                    end else begin
                        if (refresh_tick) begin
                            disp_p0 <= sel_data;
                        end
                        if (step_pulse) begin
                            ch_sel <= next_sel;
                        end
                    end
                end

                ST_FROZEN: begin
                    if (!freeze) begin
                        state <= ST_RUN;
                    end
                end

                ST_HOLD: begin
                    // A fresh hit on the release edge keeps the flag set.
                    if (step_pulse) begin
                        state <= ST_RUN;
                        if (!hit) begin
                            bp_hit <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // ---- stage p1: registered digit drive ----
    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            hex_digits <= '0;
        end else begin
            hex_digits <= pack_digits(disp_p0, ch_sel);
        end
    end

endmodule

// File: tb/tb_debug_hex_monitor.sv
module tb_debug_hex_monitor;
    import debug_pkg::*;

    localparam int NUM_CH       = 8;
    localparam int CH_W         = 16;
    localparam int NUM_DIGITS   = 6;
    localparam int DEBOUNCE_CYC = 4;
    localparam int REFRESH_DIV  = 8;

    logic                          MCLK = 1'b0;
    logic                          reset_n;
    logic [NUM_CH*CH_W-1:0]        ch_data;
    logic                          step_btn;
    logic                          freeze;
    logic                          bp_en;
    logic [15:0]                   bp_addr;
    logic [15:0]                   bus_addr;
    logic                          bus_valid;
    logic [4*NUM_DIGITS-1:0]       hex_digits;
    logic [$clog2(NUM_CH)-1:0]     ch_sel;
    logic                          bp_hit;
    logic [7:0]                    hit_count;

    int n_assert = 0;
    int n_fail   = 0;
    int found;

    debug_hex_monitor #(
        .NUM_CH       (NUM_CH),
        .CH_W         (CH_W),
        .NUM_DIGITS   (NUM_DIGITS),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REFRESH_DIV  (REFRESH_DIV)
    ) dut (
        .MCLK       (MCLK),
        .reset_n    (reset_n),
        .ch_data    (ch_data),
        .step_btn   (step_btn),
        .freeze     (freeze),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .bus_addr   (bus_addr),
        .bus_valid  (bus_valid),
        .hex_digits (hex_digits),
        .ch_sel     (ch_sel),
        .bp_hit     (bp_hit),
        .hit_count  (hit_count)
    );

    always #5 MCLK = ~MCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge MCLK);
    endtask

    task automatic set_ch(input int k, input logic [CH_W-1:0] v);
        ch_data[k*CH_W +: CH_W] = v;
    endtask

    // Clean press: held and released long enough for the filter to accept both.
    task automatic press();
        step_btn = 1'b1;
        cycles(10);
        step_btn = 1'b0;
        cycles(10);
    endtask

    initial begin
        reset_n   = 1'b0;
        ch_data   = '0;
        step_btn  = 1'b0;
        freeze    = 1'b0;
        bp_en     = 1'b0;
        bp_addr   = 16'h0000;
        bus_addr  = 16'h0000;
        bus_valid = 1'b0;
        for (int k = 0; k < NUM_CH; k++) set_ch(k, {4{4'(k)}});
        set_ch(2, 16'hBEEF);

        // Reset state
        cycles(3);
        check("rst_hex",       hex_digits, 24'h000000);
        check("rst_ch_sel",    ch_sel,     0);
        check("rst_bp_hit",    bp_hit,     0);
        check("rst_hit_count", hit_count,  0);
        check("rst_state",     dut.state,  ST_RUN);
        reset_n = 1'b1;
        cycles(2);

        // Two presses select channel 2, refresh shows it
        press();
        press();
        check("two_press_ch_sel", ch_sel, 2);
        cycles(16);
        check("ch2_display", hex_digits, 24'h20BEEF);

        // Short glitch is filtered out
        step_btn = 1'b1;
        cycles(3);
        step_btn = 1'b0;
        cycles(12);
        check("glitch_ch_sel", ch_sel, 2);

        // Walk to 7, then a full lap of 8 presses
        repeat (5) press();
        check("walk_to_7", ch_sel, 7);
        cycles(16);
        check("ch7_display", hex_digits, 24'h707777);
        press();
        check("wrap_to_0", ch_sel, 0);
        repeat (7) press();
        check("lap_back_to_7", ch_sel, 7);

        // Hit coinciding with refresh tick and step pulse
        set_ch(7, 16'h5A5A);
        bp_en   = 1'b1;
        bp_addr = 16'hC000;
        for (int i = 0; i < 20 && dut.refresh_cnt != 3'd1; i++) cycles(1);
        step_btn = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            if (dut.step_pulse) begin
                found = 1;
                break;
            end
        end
        check("step_pulse_seen", found, 1);
        check("tick_aligned", dut.refresh_tick, 1);
        bus_addr  = 16'hC000;
        bus_valid = 1'b1;
        cycles(1);
        bus_valid = 1'b0;
        bus_addr  = 16'h0000;
        check("hit_state_hold",  dut.state, ST_HOLD);
        check("hit_ch_sel_kept", ch_sel,    7);
        check("hit_count_1",     hit_count, 1);
        check("hit_bp_flag",     bp_hit,    1);
        cycles(1);
        check("hit_capture", hex_digits, 24'h705A5A);
        step_btn = 1'b0;
        cycles(10);
        check("hold_after_release", dut.state, ST_HOLD);

        // HOLD ignores data changes, freeze and refresh
        set_ch(7, 16'h1234);
        freeze = 1'b1;
        cycles(3);
        freeze = 1'b0;
        cycles(20);
        check("hold_display", hex_digits, 24'h705A5A);
        check("hold_state",   dut.state,  ST_HOLD);
        check("hold_ch_sel",  ch_sel,     7);
        press();
        check("release_state",     dut.state,  ST_RUN);
        check("release_bp_hit",    bp_hit,     0);
        check("release_hit_count", hit_count,  1);
        check("release_ch_sel",    ch_sel,     7);
        check("release_display",   hex_digits, 24'h701234);

        // Hits while frozen: counters only
        freeze = 1'b1;
        cycles(2);
        check("frozen_state", dut.state, ST_FROZEN);
        set_ch(7, 16'hFFFF);
        bus_addr  = 16'hC000;
        bus_valid = 1'b1;
        cycles(3);
        bus_addr = 16'hC001;
        cycles(2);
        bus_addr = 16'hC000;
        bp_en    = 1'b0;
        cycles(2);
        bp_en = 1'b1;
        check("count_only_real_hits", hit_count, 4);
        cycles(300);
        bus_valid = 1'b0;
        check("hit_count_saturated", hit_count,  255);
        check("frozen_kept",         dut.state,  ST_FROZEN);
        check("frozen_display",      hex_digits, 24'h701234);
        check("frozen_ch_sel",       ch_sel,     7);
        check("frozen_bp_hit",       bp_hit,     1);
        freeze = 1'b0;
        cycles(2);
        check("unfreeze_state", dut.state, ST_RUN);

        // Hit in RUN enters HOLD again; counter stays saturated
        bus_valid = 1'b1;
        cycles(1);
        bus_valid = 1'b0;
        check("rehit_state",     dut.state, ST_HOLD);
        check("rehit_count_sat", hit_count, 255);
        cycles(1);
        check("rehit_capture", hex_digits, 24'h70FFFF);

        // Asynchronous reset mid-HOLD
        cycles(5);
        #2 reset_n = 1'b0;
        #1;
        check("areset_hex",       hex_digits, 24'h000000);
        check("areset_ch_sel",    ch_sel,     0);
        check("areset_bp_hit",    bp_hit,     0);
        check("areset_hit_count", hit_count,  0);
        check("areset_state",     dut.state,  ST_RUN);
        cycles(2);
        reset_n = 1'b1;
        cycles(2);
        check("post_reset_state", dut.state, ST_RUN);
        press();
        check("post_reset_press", ch_sel, 1);
        cycles(16);
        check("post_reset_display", hex_digits, 24'h101111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
